// File: rtl/rx_byte_packer_pkg.sv
// rx_byte_packer_pkg: shared state type and constants for the RX byte packer
package rx_byte_packer_pkg;
  typedef enum logic [2:0] {IDLE, PACK, TAIL, DONE, ABORT} rx_pack_state_t;
  localparam int BYTE_LANES = 4;
  localparam logic [6:0] MAX_BYTES = 7'd64;
  localparam logic [5:0] BUF_DEPTH = 6'd63;
endpackage

// File: rtl/rx_byte_packer_if.sv
// rx_byte_packer_if: decoder-side inputs and buffer/controller-side outputs of the packer
interface rx_byte_packer_if;
  logic [7:0] rx_byte;
  logic rx_byte_valid;
  logic rx_packet_start;
  logic rx_packet_end;
  logic rx_error;
  logic [5:0] buffer_occupancy_rx;
  logic [31:0] rx_packet_data;
  logic store_rx_packet_data;
  logic flush;
  logic [6:0] rx_byte_count;
  logic rx_packet_done;
  logic rx_packet_err;
  modport master(
    output rx_byte, rx_byte_valid, rx_packet_start, rx_packet_end, rx_error, buffer_occupancy_rx,
    input rx_packet_data, store_rx_packet_data, flush, rx_byte_count, rx_packet_done, rx_packet_err
  );
  modport slave(
    input rx_byte, rx_byte_valid, rx_packet_start, rx_packet_end, rx_error, buffer_occupancy_rx,
    output rx_packet_data, store_rx_packet_data, flush, rx_byte_count, rx_packet_done, rx_packet_err
  );
endinterface

// File: rtl/rx_byte_packer_word_assembler.sv
// rx_word_assembler: little-endian 4-lane byte insert register with lane counter
module rx_word_assembler
  import rx_byte_packer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wr,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [1:0]  lane,
  output logic        word_ready
);
  logic [31:0] shreg_q, shreg_d, ins;
  logic [1:0] lane_q, lane_d;
  always_comb begin
    ins = shreg_q;
    ins[8*lane_q +: 8] = data;
    word = wr ? ins : shreg_q;
    word_ready = wr && lane_q == 2'(BYTE_LANES - 1);
    shreg_d = (clear || word_ready) ? '0 : word;
    lane_d = clear ? '0 : lane_q + 2'(wr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      lane_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      lane_q <= lane_d;
    end
  end
  assign lane = lane_q;
endmodule

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs RX payload bytes into 32-bit words for the RX buffer with abort handling
module rx_byte_packer
  import rx_byte_packer_pkg::*;
(
  input logic clk,
  input logic rst,
  rx_byte_packer_if.slave bus
);
  rx_pack_state_t state_q, state_d;
  logic [6:0] count_q, count_d;
  logic [31:0] data_q, data_d, word;
  logic store_q, store_d, clr, wr, word_ready, full, ovf;
  logic [1:0] lane;
  rx_word_assembler u_asm (
    .clk(clk), .rst(rst), .clear(clr), .wr(wr), .data(bus.rx_byte),
    .word(word), .lane(lane), .word_ready(word_ready)
  );
  assign full = bus.buffer_occupancy_rx == BUF_DEPTH;
  assign ovf = bus.rx_byte_valid && count_q == MAX_BYTES;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d = data_q;
    store_d = 1'b0;
    clr = 1'b0;
    wr = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_packet_start) begin
        state_d = PACK;
        count_d = '0;
        clr = 1'b1;
      end
      PACK: if (bus.rx_error || ovf) begin
        state_d = ABORT;
        clr = 1'b1;
      end else if (bus.rx_packet_start) begin
        count_d = '0;
        clr = 1'b1;
      end else begin
        state_d = bus.rx_packet_end ? TAIL : PACK;
        wr = bus.rx_byte_valid;
        count_d = wr ? count_q + 7'd1 : count_q;
        if (word_ready && full) begin
          state_d = ABORT;
          clr = 1'b1;
        end else if (word_ready) begin
          data_d = word;
          store_d = 1'b1;
        end
      end
      TAIL: if (bus.rx_error || ovf || (lane != 2'd0 && full)) begin
        state_d = ABORT;
        clr = 1'b1;
      end else begin
        state_d = DONE;
        clr = 1'b1;
        store_d = lane != 2'd0;
        data_d = store_d ? word : data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q <= data_d;
      store_q <= store_d;
    end
  end
  assign bus.rx_packet_data = data_q;
  assign bus.store_rx_packet_data = store_q;
  assign bus.flush = state_q == ABORT;
  assign bus.rx_packet_err = state_q == ABORT;
  assign bus.rx_packet_done = state_q == DONE;
  assign bus.rx_byte_count = count_q;
endmodule
